// File: rtl/tdm_mult_sched_pkg.sv
// Shared types and constants for the TDM / round-robin multiplier scheduler.
package tdm_sched_pkg;

  localparam int STATS_W  = 16;
  // Widest requester index needed for the supported range of 2..16 requesters.
  localparam int ID_MAX_W = 4;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    RR  = 1'b0,
    TDM = 1'b1
  } mode_e;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/tdm_mult_sched_rr_arbiter.sv
// Combinational grant selection: fixed TDM slot at ptr, or first valid request
// searching cyclically from ptr.
module rr_arbiter
  import tdm_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  mode_e              mode,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    grant_any = 1'b0;
    j         = 0;
    if (en) begin
      if (mode == TDM) begin
        if (req[ptr]) begin
          grant[ptr] = 1'b1;
          grant_any  = 1'b1;
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          j = int'(ptr) + k;
          if (j >= NUM_REQ) j = j - NUM_REQ;
          if (!grant_any && req[j]) begin
            grant[j]  = 1'b1;
            grant_idx = ID_W'(j);
            grant_any = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/tdm_mult_sched.sv
// Shares one pipelined multiplier among NUM_REQ requesters and returns id-tagged
// results. Define TDM_SCHED_STATS_EN to add per-requester saturating grant counters.
module tdm_mult_sched
  import tdm_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH_A      = 8,
  parameter int WIDTH_B      = 8,
  parameter int MULT_LATENCY = 2,
  localparam int ID_W        = id_width(NUM_REQ),
  localparam int P_W         = WIDTH_A + WIDTH_B
) (
  input  logic                              clk,
  input  logic                              rst,
`ifdef TDM_SCHED_STATS_EN
  input  logic                              stats_clr,
  output logic [NUM_REQ-1:0][STATS_W-1:0]   grant_cnt,
`endif
  input  logic                              en,
  input  logic                              tdm_mode,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][WIDTH_A-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH_B-1:0]   req_b,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              mult_valid,
  output logic [WIDTH_A-1:0]                mult_a,
  output logic [WIDTH_B-1:0]                mult_b,
  input  logic [P_W-1:0]                    mult_p,
  output logic                              res_valid,
  output logic [ID_W-1:0]                   res_id,
  output logic [P_W-1:0]                    res_data
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [ID_W-1:0]    mult_id_p0;
  mode_e              mode;
  tag_t               tag_p1 [MULT_LATENCY];

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
  endfunction

  assign mode = mode_e'(tdm_mode);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .mode      (mode),
    .en        (en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Grants are masked while reset is asserted so nothing is accepted then.
  assign req_ready = rst ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (en) begin
      if (mode == TDM)    ptr <= wrap_inc(ptr);
      else if (grant_any) ptr <= wrap_inc(grant_idx);
    end
  end

  // Stage p0: issue registers feeding the multiplier.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_valid <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      mult_id_p0 <= '0;
    end else begin
      mult_valid <= grant_any;
      if (grant_any) begin
        mult_a     <= req_a[grant_idx];
        mult_b     <= req_b[grant_idx];
        mult_id_p0 <= grant_idx;
      end
    end
  end

  // Stage p1: tag shift register tracking the multiplier's internal pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MULT_LATENCY; i++) tag_p1[i] <= '0;
    end else begin
      tag_p1[0] <= '{valid: mult_valid, id: ID_MAX_W'(mult_id_p0)};
      for (int i = 1; i < MULT_LATENCY; i++) tag_p1[i] <= tag_p1[i-1];
    end
  end

  // Stage p2: result registers, product captured only with a live tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= tag_p1[MULT_LATENCY-1].valid;
      if (tag_p1[MULT_LATENCY-1].valid) begin
        res_id   <= tag_p1[MULT_LATENCY-1].id[ID_W-1:0];
        res_data <= mult_p;
      end
    end
  end

`ifdef TDM_SCHED_STATS_EN
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] c);
    return (&c) ? c : c + STATS_W'(1);
  endfunction

  // Clear takes priority over a coincident grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
    end
  end
`endif

endmodule

// File: tb/tb_tdm_mult_sched.sv
// Directed bench for tdm_mult_sched with a two-stage multiplier model.
module tb_tdm_mult_sched;

  localparam int N  = 4;
  localparam int WA = 8;
  localparam int WB = 8;
  localparam int L  = 2;
  localparam int PW = WA + WB;
  localparam int IW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   en;
  logic                   tdm_mode;
  logic [N-1:0]           req_valid;
  logic [N-1:0][WA-1:0]   req_a;
  logic [N-1:0][WB-1:0]   req_b;
  logic [N-1:0]           req_ready;
  logic                   mult_valid;
  logic [WA-1:0]          mult_a;
  logic [WB-1:0]          mult_b;
  logic [PW-1:0]          mult_p;
  logic                   res_valid;
  logic [IW-1:0]          res_id;
  logic [PW-1:0]          res_data;
`ifdef TDM_SCHED_STATS_EN
  logic                   stats_clr;
  logic [N-1:0][15:0]     grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic [PW-1:0] p_pipe [L];
  always @(posedge clk) begin
    p_pipe[0] <= PW'(mult_a) * PW'(mult_b);
    for (int i = 1; i < L; i++) p_pipe[i] <= p_pipe[i-1];
  end
  assign mult_p = p_pipe[L-1];

  tdm_mult_sched #(
    .NUM_REQ      (N),
    .WIDTH_A      (WA),
    .WIDTH_B      (WB),
    .MULT_LATENCY (L)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
`ifdef TDM_SCHED_STATS_EN
    .stats_clr  (stats_clr),
    .grant_cnt  (grant_cnt),
`endif
    .en         (en),
    .tdm_mode   (tdm_mode),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .mult_valid (mult_valid),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_p     (mult_p),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_data   (res_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    en        = 1'b0;
    req_valid = '0;
    repeat (4) tick();
    en = 1'b1;
  endtask

  initial begin
    int  p;
    int  pulses;
    bit  mvh [12];

    rst       = 1'b0;
    en        = 1'b0;
    tdm_mode  = 1'b0;
    req_valid = '0;
    req_a     = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b     = {8'd3, 8'd3, 8'd3, 8'd3};
`ifdef TDM_SCHED_STATS_EN
    stats_clr = 1'b0;
`endif
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_mult_valid", mult_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    tick();
    tick();
    rst = 1'b1;

    // RR, all requesters valid
    en        = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rr_all_ready0", req_ready, 4'b0001);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rr_all_mv", mult_valid, 1);
      chk("rr_all_a", mult_a, ((k - 1) % 4) + 1);
      chk("rr_all_ready", req_ready, 32'(1) << (k % 4));
      chk("rr_all_rv", res_valid, (k >= 4) ? 1 : 0);
      if (k >= 4) begin
        chk("rr_all_id", res_id, (k - 4) % 4);
        chk("rr_all_data", res_data, 3 * (((k - 4) % 4) + 1));
      end
    end
    drain();

    // RR, single requester 2, then requesters 0 and 2
    req_valid = 4'b0100;
    #1;
    chk("rr_one_ready0", req_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_one_mv", mult_valid, 1);
      chk("rr_one_a", mult_a, 3);
      chk("rr_one_ready", req_ready, 4'b0100);
    end
    req_valid = 4'b1100;
    #1;
    chk("rr_ptr3", req_ready, 4'b1000);
    req_valid = 4'b0101;
    #1;
    chk("rr_alt_ready0", req_ready, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_alt_a", mult_a, (k % 2 == 0) ? 1 : 3);
      chk("rr_alt_ready", req_ready, (k % 2 == 0) ? 4'b0100 : 4'b0001);
    end
    drain();

    // TDM, only requester 1 valid; pointer sits at 3 here
    tdm_mode  = 1'b1;
    req_valid = 4'b0010;
    p         = 3;
    pulses    = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("tdm_ready", req_ready, (p == 1) ? 4'b0010 : 4'b0000);
      tick();
      mvh[k] = (p == 1);
      p      = (p + 1) % 4;
      chk("tdm_mv", mult_valid, mvh[k]);
      if (mult_valid === 1'b1) pulses++;
      if (k >= 3) begin
        chk("tdm_rv", res_valid, mvh[k-3]);
        if (mvh[k-3]) begin
          chk("tdm_id", res_id, 1);
          chk("tdm_data", res_data, 6);
        end
      end else begin
        chk("tdm_rv_early", res_valid, 0);
      end
    end
    chk("tdm_duty", pulses, 3);
    drain();

    // Maximum operands
    tdm_mode  = 1'b0;
    req_a[0]  = 8'hFF;
    req_b[0]  = 8'hFF;
    req_valid = 4'b0001;
    #1;
    chk("max_ready", req_ready, 4'b0001);
    tick();
    chk("max_a", mult_a, 8'hFF);
    chk("max_b", mult_b, 8'hFF);
    req_valid = '0;
    tick();
    chk("max_rv1", res_valid, 0);
    tick();
    chk("max_rv2", res_valid, 0);
    tick();
    chk("max_rv3", res_valid, 1);
    chk("max_id", res_id, 0);
    chk("max_data", res_data, 16'hFE01);
    tick();
    chk("max_rv4", res_valid, 0);

    // en low for three cycles with two results in flight; pointer is at 1
    req_a[0]  = 8'd1;
    req_b[0]  = 8'd3;
    req_valid = 4'b1111;
    #1;
    chk("en_ready0", req_ready, 4'b0010);
    tick();
    chk("en_a1", mult_a, 2);
    tick();
    chk("en_a2", mult_a, 3);
    en = 1'b0;
    #1;
    chk("en_off_ready", req_ready, 0);
    tick();
    chk("en_off_mv", mult_valid, 0);
    chk("en_off_ready3", req_ready, 0);
    chk("en_off_rv3", res_valid, 0);
    tick();
    chk("en_off_rv4", res_valid, 1);
    chk("en_off_id4", res_id, 1);
    chk("en_off_data4", res_data, 6);
    chk("en_off_ready4", req_ready, 0);
    tick();
    chk("en_off_rv5", res_valid, 1);
    chk("en_off_id5", res_id, 2);
    chk("en_off_data5", res_data, 9);
    chk("en_off_ready5", req_ready, 0);
    en = 1'b1;
    #1;
    chk("en_on_ready", req_ready, 4'b1000);
    tick();
    chk("en_on_mv", mult_valid, 1);
    chk("en_on_a", mult_a, 4);

    // Reset one cycle after a grant
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_mv", mult_valid, 0);
    chk("mid_rst_a", mult_a, 0);
    chk("mid_rst_b", mult_b, 0);
    chk("mid_rst_rv", res_valid, 0);
    chk("mid_rst_id", res_id, 0);
    chk("mid_rst_data", res_data, 0);
    req_valid = '0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_rv", res_valid, 0);
      chk("post_rst_mv", mult_valid, 0);
    end

`ifdef TDM_SCHED_STATS_EN
    chk("cnt_after_rst", grant_cnt[0], 0);
    req_valid = 4'b0001;
    repeat (70000) tick();
    chk("cnt_sat", grant_cnt[0], 16'hFFFF);
    chk("cnt_other", grant_cnt[1], 0);
    stats_clr = 1'b1;
    tick();
    chk("cnt_clr", grant_cnt[0], 0);
    stats_clr = 1'b0;
    tick();
    chk("cnt_after_clr", grant_cnt[0], 1);
    req_valid = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdm_mult_sched.md
Name: tdm_mult_sched

Overview:
- Scheduler that shares one pipelined DSP48 multiplier between NUM_REQ requesters.
- Each requester presents an operand pair (a, b) with valid/ready; one request per cycle is issued to the multiplier.
- Every result returns on a shared, id-tagged output bus after a fixed latency.
- Sits between the data sources and the mult instance; two arbitration modes: strict TDM slot rotation, or work-conserving round-robin.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH_A, 8, operand a width.
- WIDTH_B, 8, operand b width.
- MULT_LATENCY, 2, edges from mult_valid being sampled by the multiplier to mult_p being valid (1..8).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  grant enable; low means no new grants, pipeline drains.
- tdm_mode  in  1  1 = strict TDM slots; 0 = work-conserving round-robin.
- req_valid  in  NUM_REQ  per-requester request.
- req_a  in  NUM_REQ x WIDTH_A  per-requester operand a.
- req_b  in  NUM_REQ x WIDTH_B  per-requester operand b.
- req_ready  out  NUM_REQ  one-hot or zero; grant for this cycle.
- mult_valid  out  1  operands valid to multiplier.
- mult_a  out  WIDTH_A  registered operand a.
- mult_b  out  WIDTH_B  registered operand b.
- mult_p  in  WIDTH_A+WIDTH_B  multiplier product.
- res_valid  out  1  result valid.
- res_id  out  ID_W  requester index of result.
- res_data  out  WIDTH_A+WIDTH_B  registered product.

Behaviour:
- Reset (rst low, async):
  - All outputs 0.
  - Slot/priority pointer ptr = 0.
  - Tag pipeline cleared.
  - req_ready forced 0 while in reset.
- Handshake:
  - Transfer happens on an edge where req_valid[i] & req_ready[i].
  - req_ready is combinational from ptr, req_valid, en and tdm_mode.
  - At most one bit of req_ready is set.
  - Requester must hold a/b stable while valid is high and not yet accepted.
- TDM mode (tdm_mode=1):
  - req_ready[ptr] = en & req_valid[ptr].
  - ptr advances by 1 every cycle while en=1, whether or not the slot is used.
  - ptr wraps NUM_REQ-1 -> 0.
  - An unused slot produces a bubble (mult_valid=0).
- RR mode (tdm_mode=0):
  - Grant goes to the first valid index searching ptr, ptr+1, ... cyclically.
  - On a transfer to index g, ptr <= g+1 (wrapped).
  - With no valid requests, ptr holds.
- en=0: req_ready=0 and ptr holds. In-flight results still complete.
- Mode change:
  - Takes effect in the cycle it is sampled; ptr is not reset.
  - Toggling never drops or duplicates an accepted request.
- Issue: on a transfer at edge E, mult_a/mult_b/mult_valid=1 are registered at E. With no transfer, mult_valid=0 and mult_a/mult_b hold.
- Tag pipeline:
  - A shift register of (valid, id), depth MULT_LATENCY, aligned with mult_p.
  - At edge E+MULT_LATENCY+1: res_valid=1, res_id=g, res_data=mult_p.
  - Total latency from accept to res_valid is MULT_LATENCY+1 edges.
- Throughput and result interface:
  - Full throughput is one result per cycle; back-to-back grants give back-to-back results.
  - No backpressure on the result bus.
- Widths:
  - ID_W = max(1, $clog2(NUM_REQ)).
  - Product is unsigned, full width WIDTH_A+WIDTH_B; no truncation.
- Reset mid-operation: in-flight tags are discarded and no res_valid pulses appear after release.

Optional Feature:
- Macro TDM_SCHED_STATS_EN.
- When defined:
  - Adds output grant_cnt, NUM_REQ x 16 bits.
  - Each counter increments on its requester's transfer and saturates at 16'hFFFF.
  - Counters are reset by rst.
  - Adds input stats_clr, a synchronous clear of all counters. If clr and a grant coincide, clr wins and the counter reads 0.
- When undefined: neither port exists; no counter logic.

Decomposition:
- Package tdm_sched_pkg holds:
  - ID_W function/constant.
  - typedef tag_t {logic valid; logic [ID_W-1:0] id;}.
  - typedef mode_e {RR=0, TDM=1}.
  - Counter width constant STATS_W=16.
- Sub-module rr_arbiter:
  - Inputs: req vector, ptr, mode, en.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
  - Instantiated once; ptr register lives in the top.

Test Plan:
- RR, NUM_REQ=4, L=2, all valid, a=i+1, b=3 -> grants 0,1,2,3,0... in consecutive cycles; res_valid continuous from edge 3; res_data 3,6,9,12; res_id 0,1,2,3.
- RR, only req 2 valid -> req 2 granted every cycle and ptr stays at 3; then req 0 and 2 both valid -> grants alternate 0,2,0,2.
- TDM, only req 1 valid -> granted once per 4 cycles; mult_valid duty 1/4; res_id always 1.
- Max values a=8'hFF, b=8'hFF -> res_data=16'hFE01.
- en low for 3 cycles with 2 in flight -> both results appear, req_ready=0 throughout, ptr unchanged on re-enable.
- Assert rst low 1 cycle after a grant -> all outputs 0 immediately; no res_valid after release. With TDM_SCHED_STATS_EN: 70000 grants to req 0 -> grant_cnt[0]=16'hFFFF; stats_clr -> 0.
